// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared constants, sample type and shift clamp for the CIC filters
// Contents:
//   CIC_STAGES  number of comb and integrator stages
//   DATA_W      external sample width
//   sample_t    signed external sample
//   shift_clamp output shift = width - DATA_W - gain, clamped at 0
package cic_pkg;

  localparam int CIC_STAGES = 5;
  localparam int DATA_W     = 12;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Signed 32-bit arithmetic, so a gain larger than width-DATA_W gives a
  // negative intermediate that clamps to zero instead of wrapping.
  function automatic logic [15:0] shift_clamp(input int width, input logic [7:0] gain);
    int g;
    int s;
    g = {24'd0, gain};
    s = width - DATA_W - g;
    if (s < 0) begin
      s = 0;
    end
    return s[15:0];
  endfunction

endpackage

// File: rtl/cic_integrator_chain.sv
// rtl/cic_integrator_chain.sv - cascade of CIC_STAGES wrapping integrators at the clk rate
// Ports:
//   clk  system clock, posedge
//   rst  synchronous active-high reset, clears every integrator
//   u    integrator input, WIDTH-bit two's complement
//   i5   output of the last integrator stage
module cic_integrator_chain
  import cic_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] u,
  output logic signed [WIDTH-1:0] i5
);

  logic signed [WIDTH-1:0] r_integ [CIC_STAGES];

  // Each stage adds the previous stage's registered value, so stage k lags
  // stage k-1 by one clk. Overflow wraps on purpose and cancels against the comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CIC_STAGES; k++) begin
        r_integ[k] <= '0;
      end
    end else begin
      r_integ[0] <= r_integ[0] + u;
      for (int k = 1; k < CIC_STAGES; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  assign i5 = r_integ[CIC_STAGES-1];

endmodule

// File: rtl/cic_interpolator.sv
// rtl/cic_interpolator.sv - 5-stage CIC interpolator: low-rate comb, zero-stuff, clk-rate integrators
// Ports:
//   clk          system clock, posedge
//   rst          synchronous active-high reset
//   Gain         output scaling, shift = WIDTH-12-Gain (clamped at 0)
//   d_in         signed low-rate input sample
//   d_in_valid   d_in holds a valid sample
//   d_in_ready   high one cycle in R, the accept slot
//   d_out        signed high-rate output sample, one per clk
//   d_out_valid  pipeline primed, stays high until reset
//   underrun     one-cycle pulse after an accept slot with d_in_valid low
module cic_interpolator
  import cic_pkg::*;
#(
  parameter int WIDTH               = 64,
  parameter int INTERPOLATION_RATIO = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        Gain,
  input  logic signed [11:0] d_in,
  input  logic              d_in_valid,
  output logic              d_in_ready,
  output logic signed [11:0] d_out,
  output logic              d_out_valid,
  output logic              underrun
);

  localparam logic [15:0] LAST_PHASE = 16'(INTERPOLATION_RATIO - 1);

  logic [15:0]             r_count;
  logic                    r_ready;
  logic                    r_underrun;
  logic                    r_stuff;
  logic [6:0]              r_valid_sr;
  logic signed [WIDTH-1:0] r_z [CIC_STAGES];
  logic signed [WIDTH-1:0] r_comb_out;
  sample_t                 r_dout;

  logic [15:0]             w_count_nxt;
  logic signed [WIDTH-1:0] w_x;
  logic signed [WIDTH-1:0] w_c [CIC_STAGES];
  logic signed [WIDTH-1:0] w_u;
  logic signed [WIDTH-1:0] w_i5;
  logic [15:0]             w_shift;
  sample_t                 w_dout_nxt;

  assign w_count_nxt = (r_count == LAST_PHASE) ? 16'd0 : r_count + 16'd1;

  // An underrun slot feeds zero into the comb, keeping the filter linear.
  assign w_x = d_in_valid ? {{(WIDTH-DATA_W){d_in[DATA_W-1]}}, d_in} : '0;

  always_comb begin
    logic signed [WIDTH-1:0] acc;
    acc = w_x;
    for (int k = 0; k < CIC_STAGES; k++) begin
      acc    = acc - r_z[k];
      w_c[k] = acc;
    end
  end

  // Zero-stuffing: the comb result reaches the integrators for exactly one clk.
  assign w_u = r_stuff ? r_comb_out : '0;

  cic_integrator_chain #(
    .WIDTH (WIDTH)
  ) u_integ (
    .clk (clk),
    .rst (rst),
    .u   (w_u),
    .i5  (w_i5)
  );

  assign w_shift    = shift_clamp(WIDTH, Gain);
  assign w_dout_nxt = sample_t'(w_i5 >>> w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_stuff    <= 1'b0;
      r_valid_sr <= '0;
      r_comb_out <= '0;
      r_dout     <= '0;
      for (int k = 0; k < CIC_STAGES; k++) begin
        r_z[k] <= '0;
      end
    end else begin
      r_count    <= w_count_nxt;
      // Ready is registered from the next phase so it equals (count == R-1).
      r_ready    <= (w_count_nxt == LAST_PHASE);
      r_underrun <= r_ready & ~d_in_valid;
      r_stuff    <= r_ready;
      // Bit 0 latches the first slot; bit 6 then marks the first d_out it reaches.
      r_valid_sr <= {r_valid_sr[5:0], r_valid_sr[0] | r_ready};
      r_dout     <= w_dout_nxt;
      if (r_ready) begin
        r_z[0]     <= w_x;
        for (int k = 1; k < CIC_STAGES; k++) begin
          r_z[k] <= w_c[k-1];
        end
        r_comb_out <= w_c[CIC_STAGES-1];
      end
    end
  end

  assign d_in_ready  = r_ready;
  assign underrun    = r_underrun;
  assign d_out       = r_dout;
  assign d_out_valid = r_valid_sr[6];

endmodule

// File: tb/tb_cic_interpolator.sv
// tb/tb_cic_interpolator.sv - self-checking bench for cic_interpolator against a convolution model
module tb_cic_interpolator;

  localparam int R   = 16;
  localparam int W   = 64;
  localparam int HL  = 5 * (R - 1) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        Gain;
  logic signed [11:0] d_in;
  logic              d_in_valid;
  logic              d_in_ready;
  logic signed [11:0] d_out;
  logic              d_out_valid;
  logic              underrun;

  cic_interpolator #(
    .WIDTH               (W),
    .INTERPOLATION_RATIO (R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Gain        (Gain),
    .d_in        (d_in),
    .d_in_valid  (d_in_valid),
    .d_in_ready  (d_in_ready),
    .d_out       (d_out),
    .d_out_valid (d_out_valid),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: overall high-rate response is (1 + z^-1 + ... + z^-(R-1))^5 applied
  // to the zero-stuffed input stream, delayed by 7 clk.
  longint h [0:HL-1];
  longint s_q [$];
  int     m_c;
  logic signed [11:0] e_dout;
  logic   e_rdy, e_val, e_und;

  logic signed [11:0] h_dout [0:1023];
  logic   h_rdy [0:1023];
  logic   h_und [0:1023];

  int gains [6] = '{52, 40, 45, 48, 255, 60};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic build_h();
    longint t [0:HL-1];
    int len;
    for (int i = 0; i < HL; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int st = 0; st < 5; st++) begin
      for (int i = 0; i < HL; i++) t[i] = 0;
      for (int a = 0; a < len; a++)
        for (int b = 0; b < R; b++)
          t[a+b] += h[a];
      h = t;
      len += R - 1;
    end
  endtask

  task automatic tick();
    longint y;
    int sh;
    bit slot;
    @(posedge clk);
    if (rst) begin
      m_c = 0;
      s_q.delete();
      e_dout = '0; e_rdy = 0; e_val = 0; e_und = 0;
    end else begin
      slot = (m_c % R == R - 1);
      s_q.push_back((slot && d_in_valid) ? longint'(d_in) : 64'sd0);
      e_und = slot && !d_in_valid;
      m_c++;
      e_rdy = (m_c % R == R - 1);
      e_val = (m_c >= R + 6);
      y = 0;
      for (int j = 0; j < HL; j++) begin
        int idx;
        idx = m_c - 7 - j;
        if (idx >= 0) y += h[j] * s_q[idx];
      end
      sh = (int'(Gain) > W - 12) ? 0 : (W - 12 - int'(Gain));
      y = y >>> sh;
      e_dout = y[11:0];
    end
    #1;
    chk("d_out", d_out, e_dout);
    chk("d_out_valid", d_out_valid, e_val);
    chk("d_in_ready", d_in_ready, e_rdy);
    chk("underrun", underrun, e_und);
    if (m_c < 1024) begin
      h_dout[m_c] = d_out;
      h_rdy[m_c]  = d_in_ready;
      h_und[m_c]  = underrun;
    end
  endtask

  // mode 0: impulse in first slot; 1: constant 1; 2: random data, random drops, random Gain
  task automatic run(input int mode, input int n, input int drop);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 2) Gain = 8'(gains[$urandom_range(0, 5)]);
      if (m_c % R == R - 1) begin
        d_in_valid = (k != drop) && (mode != 2 || $urandom_range(0, 4) != 0);
        case (mode)
          0:       d_in = (k == 0) ? 12'sd1 : 12'sd0;
          1:       d_in = 12'sd1;
          default: d_in = 12'($urandom);
        endcase
        k++;
      end else begin
        d_in_valid = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 2))
          0:       d_in = 12'sd100;
          1:       d_in = 12'sd200;
          default: d_in = 12'($urandom);
        endcase
      end
      tick();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  initial begin
    build_h();
    m_c = 0;
    Gain = 8'd52;
    d_in = '0;
    d_in_valid = 1'b0;

    do_reset(2);

    run(0, 200, -1);
    chk("imp_pre", h_dout[R+5], 0);
    chk("imp_0", h_dout[R+6], 1);
    chk("imp_1", h_dout[R+7], 5);
    chk("imp_2", h_dout[R+8], 15);
    chk("imp_3", h_dout[R+9], 35);
    chk("imp_4", h_dout[R+10], 70);
    chk("imp_tail", h_dout[R+82], 0);
    chk("rdy_R-2", h_rdy[R-2], 0);
    chk("rdy_R-1", h_rdy[R-1], 1);
    chk("rdy_R", h_rdy[R], 0);
    chk("rdy_2R-1", h_rdy[2*R-1], 1);

    run(1, 40, -1);
    do_reset(3);
    chk("rst_dout", d_out, 0);
    chk("rst_valid", d_out_valid, 0);
    chk("rst_ready", d_in_ready, 0);

    run(1, 300, 3);
    chk("und_before", h_und[4*R-1], 0);
    chk("und_pulse", h_und[4*R], 1);
    chk("und_after", h_und[4*R+1], 0);
    chk("dc_g52", d_out, 0);
    Gain = 8'd40;
    run(1, 4, -1);
    chk("dc_g40", d_out, 16);

    do_reset(3);
    Gain = 8'd255;
    run(0, 200, -1);
    chk("clamp_0", h_dout[R+6], 1);
    chk("clamp_1", h_dout[R+7], 5);
    chk("clamp_2", h_dout[R+8], 15);
    chk("clamp_3", h_dout[R+9], 35);
    chk("clamp_4", h_dout[R+10], 70);

    do_reset(1);
    run(2, 2000, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
